uart_tx_scheduler: RTL and testbench

Byte-queueing transmit controller between the memory-mapped bus write strobe for the UART slot and the uart_top transmitter. The core posts bytes without polling. The block buffers them in a FIFO and feeds them to the transmitter one at a time: it pulses transmit, waits for finished_tx, then inserts an optional inter-byte gap. It also reports FIFO level plus sticky overflow and timeout flags, which the bus read path returns as the UART status word.

---
 rtl/uart_tx_scheduler_if.sv | 28 ++
 rtl/uart_tx_scheduler.sv | 165 ++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_scheduler_if.sv
// Bus-side write/status and transmitter handshake bundle for uart_tx_scheduler.
// master: bus decoder plus transmitter side; slave: the scheduler itself.
interface uart_tx_scheduler_if #(
  parameter int DEPTH = 8
);
  logic                     wr_en;
  logic [7:0]               wr_data;
  logic                     clr_flags;
  logic                     tx_done;
  logic                     tx_start;
  logic [7:0]               tx_data;
  logic [$clog2(DEPTH):0]   fifo_count;
  logic                     full;
  logic                     empty;
  logic                     busy;
  logic                     overflow;
  logic                     timeout_err;

  modport master (
    output wr_en, wr_data, clr_flags, tx_done,
    input  tx_start, tx_data, fifo_count, full, empty, busy, overflow, timeout_err
  );

  modport slave (
    input  wr_en, wr_data, clr_flags, tx_done,
    output tx_start, tx_data, fifo_count, full, empty, busy, overflow, timeout_err
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Byte FIFO feeding a UART transmitter one byte at a time, with optional inter-byte gap,
// tx_done timeout and sticky status flags. Define UART_TX_SCHED_IRQ_EN to add the irq output.
module uart_tx_scheduler #(
  parameter int DEPTH          = 8,
  parameter int GAP_CYCLES     = 0,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst_n,
`ifdef UART_TX_SCHED_IRQ_EN
  output logic irq,
`endif
  uart_tx_scheduler_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_e;

  state_e          state_q, state_d;
  logic [7:0]      mem_q [DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            tx_start_q, tx_start_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            full_q, full_d;
  logic            empty_q, empty_d;
  logic            busy_q, busy_d;
  logic            overflow_q, overflow_d;
  logic            timeout_err_q, timeout_err_d;
  logic            irq_q, irq_d;

  logic            pop, push, ovf_set, tmo_set;

  always_comb begin
    pop     = (state_q == IDLE) && !empty_q;
    // A write into a full FIFO still lands when the head leaves in the same cycle.
    push    = bus.wr_en && (!full_q || pop);
    ovf_set = bus.wr_en && full_q && !pop;
    tmo_set = 1'b0;

    state_d   = state_q;
    tmo_d     = tmo_q;
    gap_d     = gap_q;
    tx_data_d = tx_data_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;

    unique case (state_q)
      IDLE: begin
        if (pop) begin
          tx_data_d = mem_q[rd_ptr_q];
          rd_ptr_d  = rd_ptr_q + PW'(1);
          state_d   = START;
        end
      end
      START: begin
        tmo_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.tx_done) begin
          if (GAP_CYCLES > 0) begin
            gap_d   = '0;
            state_d = GAP;
          end else begin
            state_d = IDLE;
          end
        end else if (tmo_q == TMO_LAST) begin
          tmo_set = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) state_d = IDLE;
        else                   gap_d   = gap_q + GW'(1);
      end
      default: state_d = IDLE;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);

    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    tx_start_d    = (state_d == START);
    full_d        = (count_d == DEPTH_C);
    empty_d       = (count_d == '0);
    busy_d        = (state_d != IDLE) || !empty_d;
    // A new set event outranks a coincident clear.
    overflow_d    = ovf_set || (overflow_q && !bus.clr_flags);
    timeout_err_d = tmo_set || (timeout_err_q && !bus.clr_flags);
    irq_d         = (busy_q && !busy_d) || ovf_set || tmo_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      tmo_q         <= '0;
      gap_q         <= '0;
      tx_start_q    <= 1'b0;
      tx_data_q     <= 8'h00;
      full_q        <= 1'b0;
      empty_q       <= 1'b1;
      busy_q        <= 1'b0;
      overflow_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      irq_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      tmo_q         <= tmo_d;
      gap_q         <= gap_d;
      tx_start_q    <= tx_start_d;
      tx_data_q     <= tx_data_d;
      full_q        <= full_d;
      empty_q       <= empty_d;
      busy_q        <= busy_d;
      overflow_q    <= overflow_d;
      timeout_err_q <= timeout_err_d;
      irq_q         <= irq_d;
    end
  end

  // Storage needs no reset: pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.wr_data;
  end

  assign bus.tx_start    = tx_start_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.fifo_count  = count_q;
  assign bus.full        = full_q;
  assign bus.empty       = empty_q;
  assign bus.busy        = busy_q;
  assign bus.overflow    = overflow_q;
  assign bus.timeout_err = timeout_err_q;

`ifdef UART_TX_SCHED_IRQ_EN
  assign irq = irq_q;
`else
  logic unused_irq;
  assign unused_irq = irq_q;
`endif

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with DEPTH=8, GAP_CYCLES=3, TIMEOUT_CYCLES=10.
module tb_uart_tx_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

`ifdef UART_TX_SCHED_IRQ_EN
  logic irq;
`endif

  uart_tx_scheduler_if #(.DEPTH(8)) bus ();

  uart_tx_scheduler #(
    .DEPTH(8),
    .GAP_CYCLES(3),
    .TIMEOUT_CYCLES(10)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef UART_TX_SCHED_IRQ_EN
    .irq(irq),
`endif
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] b);
    bus.wr_en   = 1'b1;
    bus.wr_data = b;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  // Called one cycle into START; answers the byte and times the next tx_start.
  task automatic done_then_next(input logic [7:0] exp, input string tag);
    int n;
    n = 0;
    tick();
    tick();
    bus.tx_done = 1'b1;
    do begin
      tick();
      bus.tx_done = 1'b0;
      n++;
    end while (!bus.tx_start && n < 20);
    chk({tag, "_spacing"}, n, 5);
    chk({tag, "_data"}, bus.tx_data, exp);
  endtask

  task automatic done_then_idle(input string tag);
    int n;
    n = 0;
    tick();
    tick();
    bus.tx_done = 1'b1;
    do begin
      tick();
      bus.tx_done = 1'b0;
      n++;
    end while (bus.busy && n < 20);
    chk({tag, "_idle_after"}, n, 4);
    chk({tag, "_count"}, bus.fifo_count, 0);
  endtask

  initial begin
    int n;
    bus.wr_en     = 1'b0;
    bus.wr_data   = 8'h00;
    bus.clr_flags = 1'b0;
    bus.tx_done   = 1'b0;

    // Reset values
    tick();
    tick();
    chk("rst_count", bus.fifo_count, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_tx_start", bus.tx_start, 0);
    chk("rst_tx_data", bus.tx_data, 8'h00);
    chk("rst_busy", bus.busy, 0);
    chk("rst_overflow", bus.overflow, 0);
    chk("rst_timeout", bus.timeout_err, 0);
    rst_n = 1'b1;
    tick();

    // Single byte
    wr(8'hA5);
    chk("t1_empty", bus.empty, 0);
    chk("t1_count", bus.fifo_count, 1);
    chk("t1_start_early", bus.tx_start, 0);
    chk("t1_busy", bus.busy, 1);
    tick();
    chk("t1_start", bus.tx_start, 1);
    chk("t1_data", bus.tx_data, 8'hA5);
    chk("t1_count_popped", bus.fifo_count, 0);
`ifdef UART_TX_SCHED_IRQ_EN
    chk("t1_irq_quiet", irq, 0);
`endif
    done_then_idle("t1");
`ifdef UART_TX_SCHED_IRQ_EN
    chk("t1_irq_drain", irq, 1);
    tick();
    chk("t1_irq_pulse", irq, 0);
`endif
    chk("t1_timeout", bus.timeout_err, 0);

    // Ordering and gap spacing
    wr(8'h11);
    wr(8'h22);
    chk("t3_start", bus.tx_start, 1);
    chk("t3_data0", bus.tx_data, 8'h11);
    wr(8'h33);
    chk("t3_start_single", bus.tx_start, 0);
    chk("t3_count", bus.fifo_count, 2);
    done_then_next(8'h22, "t3_b1");
    done_then_next(8'h33, "t3_b2");
    done_then_idle("t3_end");

    // Burst fill, overflow, clear, full with simultaneous pop
    for (int d = 1; d <= 9; d++) wr(8'(d));
    chk("t2_count_full", bus.fifo_count, 8);
    chk("t2_full", bus.full, 1);
    chk("t2_no_overflow", bus.overflow, 0);
    wr(8'h0A);
    chk("t2_overflow", bus.overflow, 1);
    chk("t2_count_held", bus.fifo_count, 8);
`ifdef UART_TX_SCHED_IRQ_EN
    chk("t2_irq_ovf", irq, 1);
`endif
    bus.clr_flags = 1'b1;
    tick();
    bus.clr_flags = 1'b0;
    chk("t2_clr", bus.overflow, 0);
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    chk("t2_no_timeout", bus.timeout_err, 0);
    tick();
    tick();
    tick();
    chk("t5_idle_full", bus.full, 1);
    wr(8'h0B);
    chk("t5_count", bus.fifo_count, 8);
    chk("t5_full", bus.full, 1);
    chk("t5_overflow", bus.overflow, 0);
    chk("t5_start", bus.tx_start, 1);
    chk("t5_data", bus.tx_data, 8'h02);
    for (int d = 3; d <= 9; d++) done_then_next(8'(d), "t2_drain");
    done_then_next(8'h0B, "t5_accepted");
    done_then_idle("t2_end");

    // Timeout
    wr(8'h5A);
    tick();
    chk("t4_start", bus.tx_start, 1);
    chk("t4_data", bus.tx_data, 8'h5A);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.timeout_err && n < 30);
    chk("t4_timeout_cycles", n, 11);
    chk("t4_busy", bus.busy, 0);
    wr(8'hC3);
    tick();
    chk("t4_next_start", bus.tx_start, 1);
    chk("t4_next_data", bus.tx_data, 8'hC3);
    done_then_idle("t4_next");
    chk("t4_sticky", bus.timeout_err, 1);
    bus.clr_flags = 1'b1;
    tick();
    bus.clr_flags = 1'b0;
    chk("t4_clr", bus.timeout_err, 0);

    // Stray tx_done in IDLE
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    tick();
    chk("stray_busy", bus.busy, 0);
    chk("stray_start", bus.tx_start, 0);

    // Reset mid-transfer
    wr(8'hE1);
    wr(8'hE2);
    wr(8'hE3);
    wr(8'hE4);
    chk("t6_queued", bus.fifo_count, 3);
    chk("t6_busy_pre", bus.busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_count", bus.fifo_count, 0);
    chk("t6_empty", bus.empty, 1);
    chk("t6_busy", bus.busy, 0);
    chk("t6_tx_data", bus.tx_data, 8'h00);
    chk("t6_tx_start", bus.tx_start, 0);
    tick();
    rst_n = 1'b1;
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    tick();
    chk("t6_stray_busy", bus.busy, 0);
    chk("t6_stray_start", bus.tx_start, 0);
    wr(8'h7E);
    tick();
    chk("t6_after_start", bus.tx_start, 1);
    chk("t6_after_data", bus.tx_data, 8'h7E);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
